// File: rtl/mux_arb_pkg.sv
// Shared types, widths and the round-robin winner search for the 4-way lane arbiter.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } rr_pick_t;

    // First set bit scanning ptr+1, ptr+2, ... wrapping mod N_REQ.
    function automatic rr_pick_t rr_next(input logic [SEL_W-1:0] ptr,
                                         input logic [N_REQ-1:0] valid);
        rr_pick_t         res;
        logic [SEL_W-1:0] cand;
        res = '0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            cand = ptr + SEL_W'(k);
            if (!res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle around the shared lane; master = requesters and consumer, slave = arbiter.
interface mux_rr_arbiter_if import mux_arb_pkg::*; #(
    parameter int unsigned DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic                    out_valid;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;
    logic                    out_ready;
    logic [SEL_W-1:0]        sel;
    logic                    busy;
    logic                    preempt;

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last, sel, busy, preempt
    );

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last, sel, busy, preempt
    );
endinterface

// File: rtl/mux41_bit.sv
// Gate-level single-bit 4:1 mux.
module mux41_bit (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);
    assign y = (d[0] & ~s[1] & ~s[0]) |
               (d[1] & ~s[1] &  s[0]) |
               (d[2] &  s[1] & ~s[0]) |
               (d[3] &  s[1] &  s[0]);
endmodule

// File: rtl/mux41_bus.sv
// W-bit 4:1 mux built from one gate-level bit mux per bit; input lane i is d[i*W +: W].
module mux41_bus #(
    parameter int unsigned W = 8
) (
    input  logic [4*W-1:0] d,
    input  logic [1:0]     s,
    output logic [W-1:0]   y
);
    for (genvar i = 0; i < int'(W); i++) begin : g_bit
        logic [3:0] col;
        assign col = {d[3*W+i], d[2*W+i], d[W+i], d[i]};
        mux41_bit u_bit (.d(col), .s(s), .y(y[i]));
    end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin burst arbiter sharing one 4:1 data lane; grant held until last beat or HOLD_MAX beats.
module mux_rr_arbiter import mux_arb_pkg::*; #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_rr_arbiter_if.slave     bus
);
    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             preempt_q, preempt_d;

    logic [DATA_W-1:0] data_c;
    logic              last_c;
    logic              valid_c;
    logic              fire_c;
    logic              limit_c;
    logic [CNT_W:0]    cnt_inc_c;
    logic [N_REQ-1:0]  ready_c;
    rr_pick_t          pick_c;

    mux41_bus #(.W(DATA_W)) u_data_mux (.d(bus.req_data), .s(sel_q), .y(data_c));
    mux41_bus #(.W(1))      u_last_mux (.d(bus.req_last), .s(sel_q), .y(last_c));

    assign valid_c   = bus.req_valid[sel_q];
    assign fire_c    = (state_q == GRANT) && valid_c && bus.out_ready;
    assign cnt_inc_c = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(1);
    assign limit_c   = (HOLD_MAX != 0) && (cnt_inc_c == (CNT_W+1)'(HOLD_MAX));

    // Next-state, pointer, beat counter and handshake gating.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        preempt_d = 1'b0;
        ready_c   = '0;
        pick_c    = rr_next(ptr_q, bus.req_valid);
        case (state_q)
            IDLE: begin
                if (pick_c.found) begin
                    sel_d   = pick_c.idx;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                ready_c[sel_q] = bus.out_ready;
                if (fire_c) begin
                    // Counter saturates at all-ones rather than wrapping.
                    cnt_d = cnt_inc_c[CNT_W] ? cnt_q : cnt_inc_c[CNT_W-1:0];
                    if (last_c || limit_c) begin
                        state_d   = IDLE;
                        ptr_d     = sel_q;
                        preempt_d = limit_c && !last_c;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= SEL_W'(3);
            cnt_q     <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.req_ready = ready_c;
    assign bus.out_valid = (state_q == GRANT) && valid_c;
    assign bus.out_data  = data_c;
    assign bus.out_last  = last_c;
    assign bus.sel       = sel_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one instance with HOLD_MAX=4, one with HOLD_MAX=0.
module tb_mux_rr_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux_rr_arbiter_if #(.DATA_W(8)) bus_a ();
    mux_rr_arbiter_if #(.DATA_W(8)) bus_b ();

    mux_rr_arbiter #(.DATA_W(8), .HOLD_MAX(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    mux_rr_arbiter #(.DATA_W(8), .HOLD_MAX(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus_a.req_valid = '0; bus_a.req_data = '0; bus_a.req_last = '0; bus_a.out_ready = 1'b0;
        bus_b.req_valid = '0; bus_b.req_data = '0; bus_b.req_last = '0; bus_b.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    logic rdy_pat [5];
    int   idx;

    initial begin
        checks   = 0;
        failures = 0;
        rdy_pat  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset values
        clear_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_busy",    32'(bus_a.busy), 0);
        chk("rst_sel",     32'(bus_a.sel), 0);
        chk("rst_preempt", 32'(bus_a.preempt), 0);
        chk("rst_ovalid",  32'(bus_a.out_valid), 0);
        chk("rst_ready",   32'(bus_a.req_ready), 0);

        // All four requesting single-beat bursts: grants 0,1,2,3,0 with an IDLE cycle between
        rst_n = 1'b1;
        bus_a.req_valid = 4'b1111;
        bus_a.req_last  = 4'b1111;
        bus_a.out_ready = 1'b1;
        bus_a.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        #1;
        chk("rr_idle_ovalid", 32'(bus_a.out_valid), 0);
        chk("rr_idle_ready",  32'(bus_a.req_ready), 0);
        cyc();
        for (int k = 0; k < 5; k++) begin
            chk("rr_sel",    32'(bus_a.sel), 32'(k % 4));
            chk("rr_busy",   32'(bus_a.busy), 1);
            chk("rr_ovalid", 32'(bus_a.out_valid), 1);
            chk("rr_ready",  32'(bus_a.req_ready), 32'(1) << (k % 4));
            chk("rr_data",   32'(bus_a.out_data), 32'h0C0 + 32'(k % 4));
            cyc();
            chk("rr_gap_busy",  32'(bus_a.busy), 0);
            chk("rr_gap_ready", 32'(bus_a.req_ready), 0);
            cyc();
        end

        // Requester 2 burst A1,A2,A3 with out_ready toggling
        do_reset();
        bus_a.req_valid = 4'b0100;
        cyc();
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            bus_a.req_data[16 +: 8] = 8'hA1 + 8'(idx);
            bus_a.req_last = (idx == 2) ? 4'b0100 : 4'b0000;
            bus_a.out_ready = rdy_pat[k];
            #1;
            chk("b2_sel",   32'(bus_a.sel), 2);
            chk("b2_busy",  32'(bus_a.busy), 1);
            chk("b2_data",  32'(bus_a.out_data), 32'h0A1 + 32'(idx));
            chk("b2_last",  32'(bus_a.out_last), (idx == 2) ? 1 : 0);
            chk("b2_ready", 32'(bus_a.req_ready), rdy_pat[k] ? 32'h4 : 32'h0);
            if (rdy_pat[k]) idx++;
            cyc();
        end
        bus_a.req_valid = 4'b0000;
        #1;
        chk("b2_done_busy",    32'(bus_a.busy), 0);
        chk("b2_done_preempt", 32'(bus_a.preempt), 0);

        // HOLD_MAX=4: requester 1 preempted after 4 beats, requester 3 served before it returns
        do_reset();
        bus_a.req_valid = 4'b1010;
        bus_a.req_last  = 4'b1000;
        bus_a.out_ready = 1'b1;
        bus_a.req_data[24 +: 8] = 8'h77;
        cyc();
        for (int b = 0; b < 4; b++) begin
            bus_a.req_data[8 +: 8] = 8'h40 + 8'(b);
            #1;
            chk("hm_sel",     32'(bus_a.sel), 1);
            chk("hm_data",    32'(bus_a.out_data), 32'h40 + 32'(b));
            chk("hm_ready",   32'(bus_a.req_ready), 32'h2);
            chk("hm_preempt", 32'(bus_a.preempt), 0);
            cyc();
        end
        chk("hm_rel_preempt", 32'(bus_a.preempt), 1);
        chk("hm_rel_busy",    32'(bus_a.busy), 0);
        cyc();
        chk("hm_next_sel",     32'(bus_a.sel), 3);
        chk("hm_next_ready",   32'(bus_a.req_ready), 32'h8);
        chk("hm_next_preempt", 32'(bus_a.preempt), 0);
        chk("hm_next_data",    32'(bus_a.out_data), 32'h77);
        cyc();
        bus_a.req_valid = 4'b0010;
        #1;
        chk("hm_r3_preempt", 32'(bus_a.preempt), 0);
        cyc();
        chk("hm_back_sel", 32'(bus_a.sel), 1);
        for (int b = 0; b < 4; b++) begin
            bus_a.req_last = (b == 3) ? 4'b0010 : 4'b0000;
            #1;
            chk("hm2_busy", 32'(bus_a.busy), 1);
            cyc();
        end
        chk("hm2_coincide_preempt", 32'(bus_a.preempt), 0);
        chk("hm2_coincide_busy",    32'(bus_a.busy), 0);

        // Requester 0 stalls for 3 cycles mid-burst while requester 3 waits
        do_reset();
        bus_a.req_valid = 4'b1001;
        bus_a.out_ready = 1'b1;
        bus_a.req_data[0 +: 8] = 8'h50;
        cyc();
        chk("st_sel",   32'(bus_a.sel), 0);
        chk("st_ready", 32'(bus_a.req_ready), 32'h1);
        cyc();
        bus_a.req_valid = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("st_hold_ovalid", 32'(bus_a.out_valid), 0);
            chk("st_hold_r3",     32'(bus_a.req_ready[3]), 0);
            chk("st_hold_busy",   32'(bus_a.busy), 1);
            chk("st_hold_sel",    32'(bus_a.sel), 0);
            cyc();
        end
        bus_a.req_valid = 4'b1001;
        bus_a.req_last  = 4'b0001;
        bus_a.req_data[0 +: 8] = 8'h51;
        #1;
        chk("st_resume_ovalid", 32'(bus_a.out_valid), 1);
        chk("st_resume_data",   32'(bus_a.out_data), 32'h51);
        cyc();
        chk("st_rel_busy", 32'(bus_a.busy), 0);
        cyc();
        chk("st_next_sel", 32'(bus_a.sel), 3);

        // Reset during beat 2 of a requester-3 burst, with ptr moved away from 3 beforehand
        do_reset();
        bus_a.req_valid = 4'b0010;
        bus_a.req_last  = 4'b0010;
        bus_a.out_ready = 1'b1;
        cyc();
        chk("rs_pre_sel", 32'(bus_a.sel), 1);
        cyc();
        bus_a.req_valid = 4'b1000;
        bus_a.req_last  = 4'b0000;
        bus_a.req_data[24 +: 8] = 8'h60;
        #1;
        chk("rs_gap_busy", 32'(bus_a.busy), 0);
        cyc();
        chk("rs_sel",  32'(bus_a.sel), 3);
        chk("rs_data", 32'(bus_a.out_data), 32'h60);
        cyc();
        bus_a.req_data[24 +: 8] = 8'h61;
        #1;
        chk("rs_beat2_data", 32'(bus_a.out_data), 32'h61);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus_a.req_valid = 4'b1001;
        #1;
        chk("rs_busy",   32'(bus_a.busy), 0);
        chk("rs_ready",  32'(bus_a.req_ready), 0);
        chk("rs_ovalid", 32'(bus_a.out_valid), 0);
        chk("rs_selrst", 32'(bus_a.sel), 0);
        cyc();
        chk("rs_regrant_sel",  32'(bus_a.sel), 0);
        chk("rs_regrant_busy", 32'(bus_a.busy), 1);
        clear_inputs();

        // HOLD_MAX=0: 300-beat burst, never preempted, ends only on last
        bus_b.req_valid = 4'b0100;
        bus_b.out_ready = 1'b1;
        cyc();
        for (int b = 0; b < 300; b++) begin
            bus_b.req_data[16 +: 8] = 8'(b);
            bus_b.req_last = (b == 299) ? 4'b0100 : 4'b0000;
            #1;
            chk("long_busy",    32'(bus_b.busy), 1);
            chk("long_preempt", 32'(bus_b.preempt), 0);
            chk("long_data",    32'(bus_b.out_data), 32'(b % 256));
            cyc();
        end
        bus_b.req_valid = 4'b0000;
        #1;
        chk("long_end_busy",    32'(bus_b.busy), 0);
        chk("long_end_preempt", 32'(bus_b.preempt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
